dm_cache_ctrl: RTL and testbench
================================

Name: dm_cache_ctrl

Overview:
Direct-mapped, write-back, write-allocate cache plus controller FSM between the CPU and main memory. Main memory is a 1 KB, 128-bit-block memory with readWrite/addr/writeData/readData ports. The cache holds 4 lines of 128 bits with tag/valid/dirty per line, and serves single-word CPU loads and stores. On a miss it sequences write-back and line-fill transfers to main memory, holding each transfer for a fixed latency.

Parameters:
MEM_LATENCY, 4, cycles each main-memory transfer (write-back or fill) is held stable; legal range 1..15.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
cpuReq  input  1  CPU request strobe, sampled only in IDLE
cpuWrite  input  1  1 = store, 0 = load; sampled with cpuReq
cpuAddr  input  10  byte address; [9:6] tag, [5:4] index, [3:2] word, [1:0] ignored
cpuWriteData  input  32  store data; sampled with cpuReq
cpuReadData  output  32  load result; valid while cpuReady=1
cpuReady  output  1  one-cycle completion pulse, loads and stores
memReadWrite  output  1  to main memory: 1 = write block, 0 = read
memAddr  output  10  block address to main memory, bits [3:0] always 0
memWriteData  output  128  victim line during write-back
memReadData  input  128  block returned by main memory (combinational)

Behaviour:
- Reset (async, rst_n=0): state IDLE; all valid/dirty bits 0; cpuReady=0, cpuReadData=0, memReadWrite=0, memAddr=0, memWriteData=0; latency counter 0. Tag and data arrays need not be cleared.
- States: IDLE, COMPARE, WRITEBACK, ALLOCATE, RESP.
- IDLE: on cpuReq=1, latch cpuWrite/cpuAddr/cpuWriteData, go to COMPARE. No other activity.
- COMPARE: hit = valid[idx] && tag[idx]==latched tag.
  - Hit load: capture word[idx][wordSel] into cpuReadData, go to RESP.
  - Hit store: merge 32-bit word into line at wordSel, set dirty[idx]=1, go to RESP.
  - Miss with valid && dirty: go to WRITEBACK.
  - Miss otherwise: go to ALLOCATE.
- WRITEBACK: memReadWrite=1, memAddr={victimTag,idx,4'b0}, memWriteData=line[idx], all held MEM_LATENCY cycles by counter. Then memReadWrite drops to 0 and state goes to ALLOCATE. dirty[idx] cleared on exit.
- ALLOCATE: memReadWrite=0, memAddr={reqTag,idx,4'b0} held MEM_LATENCY cycles. On the last cycle, line[idx]=memReadData, tag updated, valid=1, dirty=0. Then return to COMPARE, which is now guaranteed to hit.
- RESP: cpuReady=1 for exactly one cycle, then IDLE. cpuReadData holds its value until the next load completes; for stores it is unchanged.
- Latency:
  - Hit: cpuReady high in the 2nd cycle after the edge that sampled cpuReq.
  - Clean miss: 2 + MEM_LATENCY + 1 cycles.
  - Dirty miss: 2 + 2*MEM_LATENCY + 1 cycles.
- Handshake: requester holds cpuReq/cpuWrite/cpuAddr/cpuWriteData until cpuReady, and deasserts cpuReq in the cpuReady cycle. cpuReq in IDLE on the cycle after RESP starts a new request; a back-to-back hit therefore costs 3 cycles.
- memReadWrite is 1 only in WRITEBACK, so main memory never sees a write outside that window. memAddr/memWriteData change only on state entry.
- Reset mid-transfer: all state aborts immediately, memReadWrite goes to 0 asynchronously, and all lines become invalid. A partially completed write-back is not retried.
- cpuAddr[1:0] are ignored (word-aligned access only).

Optional Feature:
CACHE_STATS_EN
- Defined: adds outputs hitCount[15:0] and missCount[15:0], reset to 0.
  - hitCount increments on each COMPARE that hits on first entry.
  - missCount increments on each COMPARE that misses; the re-entry after ALLOCATE does not count.
  - Both counters saturate at 16'hFFFF.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Main memory preloaded with word i = i, MEM_LATENCY=4. Reset, load 0x010 -> memReadWrite stays 0, memAddr=0x010 for 4 cycles, cpuReady after 7 cycles, cpuReadData=4.
- Then load 0x014 -> hit, cpuReady 2 cycles after sampling, cpuReadData=5, no memAddr change.
- Store 0xDEADBEEF to 0x018 -> hit, cpuReady after 2 cycles, no memory write. Then load 0x018 -> 0xDEADBEEF.
- Load 0x118 (index 1, new tag) -> WRITEBACK: memReadWrite=1, memAddr=0x010, memWriteData={7,0xDEADBEEF,5,4} for 4 cycles. Then fill from 0x110, cpuReadData=70, total 11 cycles. Afterwards memory words 4..7 = 4,5,0xDEADBEEF,7.
- Pull rst_n low during ALLOCATE -> memReadWrite=0 and cpuReady=0 immediately. The next load to the same address misses again (full fill observed).
- With CACHE_STATS_EN, the sequence above -> hitCount=3, missCount=2.

Source files
------------

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-back, write-allocate cache controller: 4 lines x 128 bits, 10-bit byte address.
// Optional hit/miss statistics counters are compiled in when CACHE_STATS_EN is defined.
module dm_cache_ctrl #(
    parameter int MEM_LATENCY = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cpuReq,
    input  logic         cpuWrite,
    input  logic [9:0]   cpuAddr,
    input  logic [31:0]  cpuWriteData,
    output logic [31:0]  cpuReadData,
    output logic         cpuReady,
    output logic         memReadWrite,
    output logic [9:0]   memAddr,
    output logic [127:0] memWriteData,
    input  logic [127:0] memReadData,
    output logic [2:0]   fsm_state
`ifdef CACHE_STATS_EN
    ,
    output logic [15:0]  hitCount,
    output logic [15:0]  missCount
`endif
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        COMPARE   = 3'd1,
        WRITEBACK = 3'd2,
        ALLOCATE  = 3'd3,
        RESP      = 3'd4
    } state_t;

    state_t state, next_state;

    logic [127:0] lines [4];
    logic [3:0]   tags  [4];
    logic [3:0]   valid;
    logic [3:0]   dirty;

    logic         req_write;
    logic [3:0]   req_tag;
    logic [1:0]   req_idx;
    logic [1:0]   req_word;
    logic [31:0]  req_wdata;
    logic [3:0]   cnt;
    logic         refill;

    logic hit;
    logic victim_dirty;
    logic last;
    logic addr_unused;

    assign addr_unused  = ^cpuAddr[1:0];
    assign hit          = valid[req_idx] && (tags[req_idx] == req_tag);
    assign victim_dirty = valid[req_idx] && dirty[req_idx];
    assign last         = (cnt == 4'(MEM_LATENCY - 1));

    // Write strobe comes straight from the state register so reset drops it asynchronously.
    assign memReadWrite = (state == WRITEBACK);
    assign cpuReady     = (state == RESP);
    assign fsm_state    = state;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:      if (cpuReq) next_state = COMPARE;
            COMPARE: begin
                if (hit)               next_state = RESP;
                else if (victim_dirty) next_state = WRITEBACK;
                else                   next_state = ALLOCATE;
            end
            WRITEBACK: if (last) next_state = ALLOCATE;
            ALLOCATE:  if (last) next_state = COMPARE;
            RESP:      next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            valid        <= '0;
            dirty        <= '0;
            cnt          <= '0;
            refill       <= 1'b0;
            req_write    <= 1'b0;
            req_tag      <= '0;
            req_idx      <= '0;
            req_word     <= '0;
            req_wdata    <= '0;
            cpuReadData  <= '0;
            memAddr      <= '0;
            memWriteData <= '0;
        end else begin
            state <= next_state;
            if (next_state != state)
                cnt <= '0;
            else if (state == WRITEBACK || state == ALLOCATE)
                cnt <= cnt + 4'd1;

            case (state)
                IDLE: begin
                    if (cpuReq) begin
                        req_write <= cpuWrite;
                        req_tag   <= cpuAddr[9:6];
                        req_idx   <= cpuAddr[5:4];
                        req_word  <= cpuAddr[3:2];
                        req_wdata <= cpuWriteData;
                        refill    <= 1'b0;
                    end
                end
                COMPARE: begin
                    if (hit) begin
                        if (req_write)
                            dirty[req_idx] <= 1'b1;
                        else
                            cpuReadData <= lines[req_idx][{req_word, 5'b0} +: 32];
                    end else if (victim_dirty) begin
                        memAddr      <= {tags[req_idx], req_idx, 4'b0};
                        memWriteData <= lines[req_idx];
                    end else begin
                        memAddr <= {req_tag, req_idx, 4'b0};
                    end
                end
                WRITEBACK: begin
                    if (last) begin
                        dirty[req_idx] <= 1'b0;
                        memAddr        <= {req_tag, req_idx, 4'b0};
                    end
                end
                ALLOCATE: begin
                    if (last) begin
                        valid[req_idx] <= 1'b1;
                        dirty[req_idx] <= 1'b0;
                        refill         <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Tag and data arrays carry no reset; valid bits guard them.
    always_ff @(posedge clk) begin
        if (state == COMPARE && hit && req_write)
            lines[req_idx][{req_word, 5'b0} +: 32] <= req_wdata;
        if (state == ALLOCATE && last) begin
            lines[req_idx] <= memReadData;
            tags[req_idx]  <= req_tag;
        end
    end

`ifdef CACHE_STATS_EN
    // The COMPARE pass that follows a refill is not a new lookup, so it is not counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hitCount  <= '0;
            missCount <= '0;
        end else if (state == COMPARE && !refill) begin
            if (hit) begin
                if (hitCount != 16'hFFFF) hitCount <= hitCount + 16'd1;
            end else begin
                if (missCount != 16'hFFFF) missCount <= missCount + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Directed self-checking bench for dm_cache_ctrl with a 1 KB block-memory model (word i = i).
// Stats checks are compiled in when CACHE_STATS_EN is defined.
module tb_dm_cache_ctrl;

    logic         clk;
    logic         rst_n;
    logic         cpuReq;
    logic         cpuWrite;
    logic [9:0]   cpuAddr;
    logic [31:0]  cpuWriteData;
    logic [31:0]  cpuReadData;
    logic         cpuReady;
    logic         memReadWrite;
    logic [9:0]   memAddr;
    logic [127:0] memWriteData;
    logic [127:0] memReadData;
    logic [2:0]   fsm_state;
`ifdef CACHE_STATS_EN
    logic [15:0]  hitCount;
    logic [15:0]  missCount;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [127:0] mem [64];
    logic [9:0]   addr_log [32];
    logic         rw_log   [32];
    logic [127:0] wd_log   [32];

    dm_cache_ctrl #(.MEM_LATENCY(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cpuReq       (cpuReq),
        .cpuWrite     (cpuWrite),
        .cpuAddr      (cpuAddr),
        .cpuWriteData (cpuWriteData),
        .cpuReadData  (cpuReadData),
        .cpuReady     (cpuReady),
        .memReadWrite (memReadWrite),
        .memAddr      (memAddr),
        .memWriteData (memWriteData),
        .memReadData  (memReadData),
        .fsm_state    (fsm_state)
`ifdef CACHE_STATS_EN
        ,
        .hitCount     (hitCount),
        .missCount    (missCount)
`endif
    );

    // Clock and main memory model
    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign memReadData = mem[memAddr[9:4]];

    always @(negedge clk) begin
        if (rst_n && memReadWrite)
            mem[memAddr[9:4]] = memWriteData;
    end

    // Driver: issue one request and log memory-side signals for each cycle until cpuReady.
    task automatic do_req(input logic wr, input logic [9:0] addr, input logic [31:0] wd,
                          output int lat, output logic [31:0] rd);
        for (int i = 0; i < 32; i++) begin
            addr_log[i] = '0;
            rw_log[i]   = 1'b0;
            wd_log[i]   = '0;
        end
        lat = 99;
        rd  = '0;
        cpuReq       = 1'b1;
        cpuWrite     = wr;
        cpuAddr      = addr;
        cpuWriteData = wd;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i < 32) begin
                addr_log[i] = memAddr;
                rw_log[i]   = memReadWrite;
                wd_log[i]   = memWriteData;
            end
            if (cpuReady) begin
                lat = i;
                rd  = cpuReadData;
                break;
            end
        end
        cpuReq = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cpuReq = 1'b0; cpuWrite = 1'b0; cpuAddr = '0; cpuWriteData = '0;
        repeat (3) @(negedge clk);
        n_checks++; if (cpuReady !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", cpuReady); end
        n_checks++; if (cpuReadData !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", cpuReadData); end
        n_checks++; if (memReadWrite !== 1'b0) begin n_fail++; $display("FAIL reset_rw: got %b expected 0", memReadWrite); end
        n_checks++; if (memAddr !== 10'h0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0", memAddr); end
        n_checks++; if (memWriteData !== 128'h0) begin n_fail++; $display("FAIL reset_wdata: got %h expected 0", memWriteData); end
        n_checks++; if (fsm_state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", fsm_state); end
`ifdef CACHE_STATS_EN
        n_checks++; if (hitCount !== 16'd0 || missCount !== 16'd0) begin n_fail++; $display("FAIL reset_stats: got %0d/%0d expected 0/0", hitCount, missCount); end
`endif
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_clean_miss();
        int lat;
        logic [31:0] rd;
        do_req(1'b0, 10'h010, 32'h0, lat, rd);
        n_checks++; if (lat !== 7) begin n_fail++; $display("FAIL clean_miss_latency: got %0d expected 7", lat); end
        n_checks++; if (rd !== 32'd4) begin n_fail++; $display("FAIL clean_miss_rdata: got %h expected 4", rd); end
        for (int c = 1; c <= 7; c++) begin
            n_checks++; if (rw_log[c] !== 1'b0) begin n_fail++; $display("FAIL clean_miss_rw cycle %0d: got %b expected 0", c, rw_log[c]); end
        end
        for (int c = 2; c <= 5; c++) begin
            n_checks++; if (addr_log[c] !== 10'h010) begin n_fail++; $display("FAIL clean_miss_addr cycle %0d: got %h expected 010", c, addr_log[c]); end
        end
        @(negedge clk);
        n_checks++; if (cpuReady !== 1'b0) begin n_fail++; $display("FAIL ready_pulse: got %b expected 0", cpuReady); end
    endtask

    task automatic test_hit_load();
        int lat;
        logic [31:0] rd;
        do_req(1'b0, 10'h014, 32'h0, lat, rd);
        n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL hit_load_latency: got %0d expected 2", lat); end
        n_checks++; if (rd !== 32'd5) begin n_fail++; $display("FAIL hit_load_rdata: got %h expected 5", rd); end
        n_checks++; if (addr_log[1] !== 10'h010 || addr_log[2] !== 10'h010) begin n_fail++; $display("FAIL hit_load_addr: got %h/%h expected 010", addr_log[1], addr_log[2]); end
        @(negedge clk);
    endtask

    task automatic test_store_hit();
        int lat;
        logic [31:0] rd;
        do_req(1'b1, 10'h018, 32'hDEADBEEF, lat, rd);
        n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL store_latency: got %0d expected 2", lat); end
        n_checks++; if (rw_log[1] !== 1'b0 || rw_log[2] !== 1'b0) begin n_fail++; $display("FAIL store_mem_write: got %b%b expected 00", rw_log[1], rw_log[2]); end
        n_checks++; if (mem[1] !== {32'd7, 32'd6, 32'd5, 32'd4}) begin n_fail++; $display("FAIL store_mem_untouched: got %h expected 7/6/5/4", mem[1]); end
        @(negedge clk);
        n_checks++; if (cpuReadData !== 32'd5) begin n_fail++; $display("FAIL store_rdata_hold: got %h expected 5", cpuReadData); end
        do_req(1'b0, 10'h018, 32'h0, lat, rd);
        n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL load_after_store_latency: got %0d expected 2", lat); end
        n_checks++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL load_after_store_rdata: got %h expected deadbeef", rd); end
        @(negedge clk);
    endtask

    task automatic test_dirty_miss();
        int lat;
        logic [31:0] rd;
        logic [127:0] victim;
        victim = {32'd7, 32'hDEADBEEF, 32'd5, 32'd4};
        do_req(1'b0, 10'h118, 32'h0, lat, rd);
        n_checks++; if (lat !== 11) begin n_fail++; $display("FAIL dirty_miss_latency: got %0d expected 11", lat); end
        n_checks++; if (rd !== 32'd70) begin n_fail++; $display("FAIL dirty_miss_rdata: got %h expected 46", rd); end
        for (int c = 1; c <= 11; c++) begin
            n_checks++;
            if (rw_log[c] !== ((c >= 2 && c <= 5) ? 1'b1 : 1'b0)) begin
                n_fail++; $display("FAIL dirty_miss_rw cycle %0d: got %b", c, rw_log[c]);
            end
        end
        for (int c = 2; c <= 5; c++) begin
            n_checks++; if (addr_log[c] !== 10'h010) begin n_fail++; $display("FAIL wb_addr cycle %0d: got %h expected 010", c, addr_log[c]); end
            n_checks++; if (wd_log[c] !== victim) begin n_fail++; $display("FAIL wb_data cycle %0d: got %h expected %h", c, wd_log[c], victim); end
        end
        for (int c = 6; c <= 9; c++) begin
            n_checks++; if (addr_log[c] !== 10'h110) begin n_fail++; $display("FAIL fill_addr cycle %0d: got %h expected 110", c, addr_log[c]); end
        end
        n_checks++; if (mem[1] !== victim) begin n_fail++; $display("FAIL wb_memory: got %h expected %h", mem[1], victim); end
        @(negedge clk);
    endtask

    task automatic test_stats();
`ifdef CACHE_STATS_EN
        n_checks++; if (hitCount !== 16'd3) begin n_fail++; $display("FAIL hit_count: got %0d expected 3", hitCount); end
        n_checks++; if (missCount !== 16'd2) begin n_fail++; $display("FAIL miss_count: got %0d expected 2", missCount); end
`endif
    endtask

    task automatic test_reset_alloc();
        int lat;
        logic [31:0] rd;
        cpuReq = 1'b1; cpuWrite = 1'b0; cpuAddr = 10'h200; cpuWriteData = '0;
        repeat (3) @(negedge clk);
        n_checks++; if (memAddr !== 10'h200) begin n_fail++; $display("FAIL alloc_addr_before_reset: got %h expected 200", memAddr); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (memReadWrite !== 1'b0) begin n_fail++; $display("FAIL alloc_reset_rw: got %b expected 0", memReadWrite); end
        n_checks++; if (cpuReady !== 1'b0) begin n_fail++; $display("FAIL alloc_reset_ready: got %b expected 0", cpuReady); end
        n_checks++; if (memAddr !== 10'h0) begin n_fail++; $display("FAIL alloc_reset_addr: got %h expected 0", memAddr); end
        n_checks++; if (fsm_state !== 3'd0) begin n_fail++; $display("FAIL alloc_reset_state: got %0d expected 0", fsm_state); end
`ifdef CACHE_STATS_EN
        n_checks++; if (hitCount !== 16'd0 || missCount !== 16'd0) begin n_fail++; $display("FAIL alloc_reset_stats: got %0d/%0d expected 0/0", hitCount, missCount); end
`endif
        @(negedge clk);
        cpuReq = 1'b0;
        rst_n  = 1'b1;
        @(negedge clk);
        do_req(1'b0, 10'h200, 32'h0, lat, rd);
        n_checks++; if (lat !== 7) begin n_fail++; $display("FAIL refetch_latency: got %0d expected 7", lat); end
        n_checks++; if (rd !== 32'd128) begin n_fail++; $display("FAIL refetch_rdata: got %h expected 80", rd); end
        for (int c = 2; c <= 5; c++) begin
            n_checks++; if (addr_log[c] !== 10'h200) begin n_fail++; $display("FAIL refetch_addr cycle %0d: got %h expected 200", c, addr_log[c]); end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_writeback();
        int lat;
        logic [31:0] rd;
        do_req(1'b1, 10'h200, 32'h12345678, lat, rd);
        n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL wb_setup_store_latency: got %0d expected 2", lat); end
        @(negedge clk);
        cpuReq = 1'b1; cpuWrite = 1'b0; cpuAddr = 10'h000; cpuWriteData = '0;
        repeat (3) @(negedge clk);
        n_checks++; if (memReadWrite !== 1'b1) begin n_fail++; $display("FAIL wb_before_reset_rw: got %b expected 1", memReadWrite); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (memReadWrite !== 1'b0) begin n_fail++; $display("FAIL wb_reset_rw: got %b expected 0", memReadWrite); end
        n_checks++; if (memWriteData !== 128'h0) begin n_fail++; $display("FAIL wb_reset_wdata: got %h expected 0", memWriteData); end
        @(negedge clk);
        cpuReq = 1'b0;
        rst_n  = 1'b1;
        @(negedge clk);
        do_req(1'b0, 10'h200, 32'h0, lat, rd);
        n_checks++; if (lat !== 7) begin n_fail++; $display("FAIL post_wb_reset_latency: got %0d expected 7", lat); end
        n_checks++; if (rd !== 32'h12345678) begin n_fail++; $display("FAIL post_wb_reset_rdata: got %h expected 12345678", rd); end
        @(negedge clk);
    endtask

    initial begin
        for (int b = 0; b < 64; b++)
            for (int w = 0; w < 4; w++)
                mem[b][w*32 +: 32] = 32'(b * 4 + w);
        test_reset();
        test_clean_miss();
        test_hit_load();
        test_store_hit();
        test_dirty_miss();
        test_stats();
        test_reset_alloc();
        test_reset_writeback();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
